count_seq_monitor: RTL and testbench

Receive-side companion to the mod-7 sequence counter: consumes a 3-bit count stream, locks onto the 0→6→0 sequence, and reports lock status, wrap events and sequence errors. Sits at the far end of any path that carries the counter value, such as a cross-block link or a test harness. Flywheels through isolated errors and drops lock only after repeated misses.

---
 rtl/count_seq_pkg.sv | 19 +
 rtl/sat_counter.sv | 22 ++
 rtl/count_seq_monitor.sv | 124 ++++++++++++
 tb/tb_count_seq_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared definitions for the mod-7 sequence counter and its receive-side monitor.
package count_seq_pkg;

  localparam int unsigned MOD_DEFAULT = 7;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } mon_state_t;

  function automatic logic [2:0] nxt(input logic [2:0] p,
                                     input int unsigned modulus = MOD_DEFAULT);
    logic [2:0] last;
    last = 3'(modulus - 1);
    return (p == last) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that wins over a simultaneous increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Locks onto a mod-MOD count stream, flywheels through isolated errors and
// reports lock, wrap and error events.
module count_seq_monitor
  import count_seq_pkg::*;
#(
  parameter int unsigned MOD      = MOD_DEFAULT,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       q_in,
  input  logic             in_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic [2:0]       expected,
  output logic             wrap_pulse,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CNT_W = 8;

  mon_state_t       state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic             wrap_d, err_d;
  logic [2:0]       exp_nxt;
  logic             illegal;
  logic             hit;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    miss_d  = miss_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    exp_nxt = nxt(prev_q, MOD);
    illegal = (32'(q_in) >= MOD);
    hit     = (q_in == exp_nxt);

    if (in_valid) begin
      unique case (state_q)
        UNLOCKED: begin
          if (!illegal) begin
            prev_d  = q_in;
            match_d = '0;
            state_d = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (illegal) begin
            state_d = UNLOCKED;
          end else if (hit) begin
            prev_d  = q_in;
            match_d = match_q + CNT_W'(1);
            if (match_d == CNT_W'(LOCK_CNT)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else begin
            prev_d  = q_in;
            match_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            prev_d = q_in;
            miss_d = '0;
            wrap_d = (q_in == 3'd0);
          end else begin
            // Flywheel: advance as if the expected value had arrived.
            prev_d = exp_nxt;
            err_d  = 1'b1;
            miss_d = miss_q + CNT_W'(1);
            if (miss_d == CNT_W'(LOSS_CNT)) begin
              state_d = UNLOCKED;
              match_d = '0;
              miss_d  = '0;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= UNLOCKED;
      prev_q     <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      locked     <= 1'b0;
      expected   <= '0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      locked     <= (state_d == LOCKED);
      // Outside LOCKED the last prediction is held rather than tracking prev.
      expected   <= (state_d == LOCKED) ? nxt(prev_d, MOD) : expected;
      wrap_pulse <= wrap_d;
      err_pulse  <= err_d;
    end
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (err_d),
    .clr    (err_clr),
    .count  (err_count)
  );

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed vector table plus randomized stream vs a reference model.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] q_in = 3'd0;

  logic       a_locked, a_wrap, a_err;
  logic [2:0] a_exp;
  logic [7:0] a_ec;
  logic       b_locked, b_wrap, b_err;
  logic [2:0] b_exp;
  logic [1:0] b_ec;

  count_seq_monitor dut (
    .clk(clk), .reset_n(reset_n), .q_in(q_in), .in_valid(in_valid), .err_clr(err_clr),
    .locked(a_locked), .expected(a_exp), .wrap_pulse(a_wrap), .err_pulse(a_err),
    .err_count(a_ec)
  );

  count_seq_monitor #(.ERR_W(2)) dut_w2 (
    .clk(clk), .reset_n(reset_n), .q_in(q_in), .in_valid(in_valid), .err_clr(err_clr),
    .locked(b_locked), .expected(b_exp), .wrap_pulse(b_wrap), .err_pulse(b_err),
    .err_count(b_ec)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tracks the stream in plain integer terms.
  bit m_locked, m_tracking, m_wrap, m_err;
  int m_prev, m_run, m_miss, m_exp, m_ec8, m_ec2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int q, input bit c);
    int want;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (!r) begin
      m_locked = 0; m_tracking = 0; m_prev = 0; m_run = 0; m_miss = 0;
      m_exp = 0; m_ec8 = 0; m_ec2 = 0;
      return;
    end
    if (v) begin
      want = (m_prev + 1) % 7;
      if (m_locked) begin
        if (q == want) begin
          m_prev = q; m_miss = 0; m_wrap = (q == 0);
        end else begin
          m_prev = want; m_err = 1'b1; m_miss++;
          if (m_miss == 2) begin
            m_locked = 0; m_tracking = 0; m_run = 0; m_miss = 0;
          end
        end
      end else if (m_tracking) begin
        if (q >= 7) m_tracking = 0;
        else if (q == want) begin
          m_prev = q; m_run++;
          if (m_run == 3) begin m_locked = 1; m_miss = 0; end
        end else begin
          m_prev = q; m_run = 0;
        end
      end else if (q < 7) begin
        m_tracking = 1; m_prev = q; m_run = 0;
      end
    end
    if (c) begin
      m_ec8 = 0; m_ec2 = 0;
    end else if (m_err) begin
      if (m_ec8 < 255) m_ec8++;
      if (m_ec2 < 3) m_ec2++;
    end
    if (m_locked) m_exp = (m_prev + 1) % 7;
  endtask

  task automatic compare_model();
    check("model_locked",   int'(a_locked), int'(m_locked));
    check("model_expected", int'(a_exp),    m_exp);
    check("model_wrap",     int'(a_wrap),   int'(m_wrap));
    check("model_err",      int'(a_err),    int'(m_err));
    check("model_errcnt",   int'(a_ec),     m_ec8);
    check("w2_locked",      int'(b_locked), int'(m_locked));
    check("w2_expected",    int'(b_exp),    m_exp);
    check("w2_wrap",        int'(b_wrap),   int'(m_wrap));
    check("w2_err",         int'(b_err),    int'(m_err));
    check("w2_errcnt",      int'(b_ec),     m_ec2);
  endtask

  task automatic step(input bit r, input bit v, input int q, input bit c);
    @(negedge clk);
    reset_n  = r;
    in_valid = v;
    q_in     = 3'(q);
    err_clr  = c;
    @(posedge clk);
    model_step(r, v, q, c);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit r; bit v; int q; bit c;
    int l; int e; int w; int er; int ec; int ec2;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input bit r, input bit v, input int q, input bit c,
                     input int l, input int e, input int w, input int er,
                     input int ec, input int ec2);
    vec_t t;
    t = '{r: r, v: v, q: q, c: c, l: l, e: e, w: w, er: er, ec: ec, ec2: ec2};
    tbl.push_back(t);
  endtask

  initial begin
    int src, q;
    bit r, v, c;

    //   r  v  q  c   lock exp wrap err ec8 ec2
    row(0, 0, 0, 0,  0, 0, 0, 0, 0, 0);   // reset
    row(1, 1, 0, 0,  0, 0, 0, 0, 0, 0);   // lock-up 0,1,2,3
    row(1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 2, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 3, 0,  1, 4, 0, 0, 0, 0);
    row(1, 1, 4, 0,  1, 5, 0, 0, 0, 0);
    row(1, 1, 5, 0,  1, 6, 0, 0, 0, 0);   // wrap 5,6,0
    row(1, 1, 6, 0,  1, 0, 0, 0, 0, 0);
    row(1, 1, 0, 0,  1, 1, 1, 0, 0, 0);
    row(1, 1, 1, 0,  1, 2, 0, 0, 0, 0);
    row(1, 1, 5, 0,  1, 3, 0, 1, 1, 1);   // flywheel 5 then 3
    row(1, 1, 3, 0,  1, 4, 0, 0, 1, 1);
    row(1, 1, 4, 0,  1, 5, 0, 0, 1, 1);
    row(1, 1, 5, 0,  1, 6, 0, 0, 1, 1);
    row(1, 1, 6, 0,  1, 0, 0, 0, 1, 1);
    row(1, 1, 0, 0,  1, 1, 1, 0, 1, 1);
    row(1, 1, 1, 0,  1, 2, 0, 0, 1, 1);
    row(1, 1, 5, 0,  1, 3, 0, 1, 2, 2);   // loss 5,5
    row(1, 1, 5, 0,  0, 3, 0, 1, 3, 3);
    row(1, 1, 7, 0,  0, 3, 0, 0, 3, 3);   // illegal stays unlocked
    row(1, 1, 1, 0,  0, 3, 0, 0, 3, 3);   // re-lock 1,2,3,4
    row(1, 1, 2, 0,  0, 3, 0, 0, 3, 3);
    row(1, 1, 3, 0,  0, 3, 0, 0, 3, 3);
    row(1, 1, 4, 0,  1, 5, 0, 0, 3, 3);
    row(1, 0, 2, 0,  1, 5, 0, 0, 3, 3);   // idle
    row(1, 1, 0, 1,  1, 6, 0, 1, 0, 0);   // clr with error
    row(1, 0, 0, 0,  1, 6, 0, 0, 0, 0);
    row(1, 1, 6, 0,  1, 0, 0, 0, 0, 0);
    row(0, 1, 3, 0,  0, 0, 0, 0, 0, 0);   // reset with mismatch
    row(1, 1, 2, 0,  0, 0, 0, 0, 0, 0);   // gapped acquisition
    row(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 3, 0,  0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 4, 0,  0, 0, 0, 0, 0, 0);
    row(1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    row(1, 1, 5, 0,  1, 6, 0, 0, 0, 0);
    row(1, 1, 3, 0,  1, 0, 0, 1, 1, 1);   // four interleaved errors
    row(1, 1, 0, 0,  1, 1, 1, 0, 1, 1);
    row(1, 1, 3, 0,  1, 2, 0, 1, 2, 2);
    row(1, 1, 2, 0,  1, 3, 0, 0, 2, 2);
    row(1, 1, 0, 0,  1, 4, 0, 1, 3, 3);
    row(1, 1, 4, 0,  1, 5, 0, 0, 3, 3);
    row(1, 1, 0, 0,  1, 6, 0, 1, 4, 3);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].q, tbl[i].c);
      check("vec_locked",   int'(a_locked), tbl[i].l);
      check("vec_expected", int'(a_exp),    tbl[i].e);
      check("vec_wrap",     int'(a_wrap),   tbl[i].w);
      check("vec_err",      int'(a_err),    tbl[i].er);
      check("vec_errcnt",   int'(a_ec),     tbl[i].ec);
      check("vec_errcnt2",  int'(b_ec),     tbl[i].ec2);
    end

    step(0, 0, 0, 0);
    src = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      if (v) begin
        q = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : src;
        src = (src + 1) % 7;
      end else begin
        q = int'($urandom_range(0, 7));
      end
      step(r, v, q, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
